// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor: fast-domain receiver for a divided slow clock.
// Synchronises slow_clk_i, emits one tick per slow rising edge, measures the slow period,
// tracks lock against EXP_PERIOD and flags a missing slow clock after TIMEOUT cycles.
// Optional feature macro: DUTY_MEASURE_EN (adds high-time measurement on high_o).
module slow_clk_monitor #(
   parameter int unsigned CNT_W      = 28,
   parameter int unsigned EXP_PERIOD = 67108864,
   parameter int unsigned TOL        = 1024,
   parameter int unsigned TIMEOUT    = 134217728,
   parameter int unsigned LOCK_CNT   = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             slow_clk_i,
   output logic             tick_o,
   output logic [CNT_W-1:0] period_o,
   output logic             period_vld_o,
   output logic             locked_o,
   output logic             lost_o,
   output logic             err_o,
   output logic [CNT_W-1:0] high_o
);

   // Range limits are one bit wider than the counter so P = per_cnt + 1 never wraps.
   localparam int unsigned LO_INT = (EXP_PERIOD >= TOL) ? (EXP_PERIOD - TOL) : 0;
   localparam int unsigned HI_INT = EXP_PERIOD + TOL;
   localparam logic [CNT_W:0]   LO_BOUND    = (CNT_W+1)'(LO_INT);
   localparam logic [CNT_W:0]   HI_BOUND    = (CNT_W+1)'(HI_INT);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
   localparam int unsigned      GOOD_W      = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
   localparam logic [GOOD_W-1:0] GOOD_LAST  = GOOD_W'(LOCK_CNT - 1);

   // Elaboration-time sanity checks on the configuration.
   if (LOCK_CNT < 1) begin : g_bad_lock_cnt
      $error("slow_clk_monitor: LOCK_CNT must be at least 1");
   end
   if (TIMEOUT <= HI_INT) begin : g_bad_timeout_lo
      $error("slow_clk_monitor: TIMEOUT must exceed EXP_PERIOD + TOL");
   end
   if (CNT_W < 32) begin : g_chk_timeout_hi
      if (TIMEOUT >= (64'd1 << CNT_W)) begin : g_bad_timeout_hi
         $error("slow_clk_monitor: TIMEOUT must fit in CNT_W bits");
      end
   end

   typedef enum logic [1:0] {
      StIdle,
      StAcq,
      StLocked,
      StLost
   } state_e;

   // Synchroniser, edge detector and validity pipeline.
   logic s1_q, s2_q, s3_q;
   logic v1_q, v2_q;
   logic rise;

   // Period counter and capture path.
   logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
   logic [CNT_W:0]    p_ext;
   logic              in_range;
   logic              timeout_hit;

   // FSM and lock bookkeeping.
   state_e            state_q, state_d;
   logic [GOOD_W-1:0] good_q, good_d;
   logic              cap;
   logic              err_d;

   // Registered outputs.
   logic              tick_q;
   logic              vld_q;
   logic              err_q;
   logic [CNT_W-1:0]  period_q;

   // Two-flop synchroniser plus edge flop; s3 is held high until s2 carries a real sample so a
   // slow clock that is already high at reset release is not mistaken for a rising edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b1;
         v1_q <= 1'b0;
         v2_q <= 1'b0;
      end else begin
         s1_q <= slow_clk_i;
         s2_q <= s1_q;
         s3_q <= v2_q ? s2_q : 1'b1;
         v1_q <= 1'b1;
         v2_q <= v1_q;
      end
   end

   assign rise = s2_q & ~s3_q;

   // Measured period of the cycle ending with this rise, and its tolerance check.
   assign p_ext       = {1'b0, per_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign in_range    = (p_ext >= LO_BOUND) && (p_ext <= HI_BOUND);
   assign timeout_hit = (per_cnt_q == TIMEOUT_VAL) && !rise;

   // Period counter: restarts on every rise, otherwise counts up and saturates at TIMEOUT.
   always_comb begin
      per_cnt_d = per_cnt_q;
      if (rise) begin
         per_cnt_d = '0;
      end else if (per_cnt_q != TIMEOUT_VAL) begin
         per_cnt_d = per_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Lock FSM next state; a rise always takes priority over the timeout.
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      cap     = 1'b0;
      err_d   = 1'b0;
      if (rise) begin
         unique case (state_q)
            StIdle: begin
               state_d = StAcq;
               good_d  = '0;
            end
            StAcq: begin
               cap = 1'b1;
               if (in_range) begin
                  good_d = good_q + {{(GOOD_W-1){1'b0}}, 1'b1};
                  if (good_q == GOOD_LAST) begin
                     state_d = StLocked;
                  end
               end else begin
                  good_d = '0;
               end
            end
            StLocked: begin
               cap = 1'b1;
               if (!in_range) begin
                  err_d   = 1'b1;
                  state_d = StAcq;
                  good_d  = '0;
               end
            end
            StLost: begin
               // Period spanning the outage is meaningless, so it is dropped.
               state_d = StAcq;
               good_d  = '0;
            end
            default: begin
               state_d = StIdle;
               good_d  = '0;
            end
         endcase
      end else if (timeout_hit && (state_q != StLost)) begin
         state_d = StLost;
      end
   end

   // State, counter and registered-output update.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         good_q    <= '0;
         per_cnt_q <= '0;
         tick_q    <= 1'b0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
         period_q  <= '0;
      end else begin
         state_q   <= state_d;
         good_q    <= good_d;
         per_cnt_q <= per_cnt_d;
         tick_q    <= rise;
         vld_q     <= cap;
         err_q     <= err_d;
         if (cap) begin
            period_q <= p_ext[CNT_W-1:0];
         end
      end
   end

`ifdef DUTY_MEASURE_EN
   logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
   logic [CNT_W-1:0] high_q;

   // High-time counter: counts synchronised-high cycles, restarts on every rise, saturates.
   always_comb begin
      hi_cnt_d = hi_cnt_q;
      if (rise) begin
         hi_cnt_d = '0;
      end else if (s2_q && (hi_cnt_q != TIMEOUT_VAL)) begin
         hi_cnt_d = hi_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // High time is captured alongside the period, including the current (rise) cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hi_cnt_q <= '0;
         high_q   <= '0;
      end else begin
         hi_cnt_q <= hi_cnt_d;
         if (cap) begin
            high_q <= hi_cnt_q + {{(CNT_W-1){1'b0}}, s2_q};
         end
      end
   end

   assign high_o = high_q;
`else
   assign high_o = '0;
`endif

   assign tick_o       = tick_q;
   assign period_o     = period_q;
   assign period_vld_o = vld_q;
   assign err_o        = err_q;
   assign locked_o     = (state_q == StLocked);
   assign lost_o       = (state_q == StLost);

   // Structural invariants of the status outputs.
   a_lock_lost_excl : assert property (@(posedge clk_i) disable iff (rst_i)
      !(locked_o && lost_o));
   a_err_has_vld : assert property (@(posedge clk_i) disable iff (rst_i)
      err_o |-> period_vld_o);
   a_vld_has_tick : assert property (@(posedge clk_i) disable iff (rst_i)
      period_vld_o |-> tick_o);

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Bench for slow_clk_monitor: directed slow-clock waveforms, a cycle-level model of the
// spec rules built from the sampled input history, and a few literal checkpoints.
module tb_slow_clk_monitor;

   localparam int unsigned CW   = 8;
   localparam int unsigned EXP  = 16;
   localparam int unsigned TOL  = 1;
   localparam int unsigned TMO  = 40;
   localparam int unsigned LCK  = 2;
`ifdef DUTY_MEASURE_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif

   localparam int M_IDLE = 0, M_ACQ = 1, M_LOCKED = 2, M_LOST = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          slow;
   logic          tick, vld, locked, lost, err;
   logic [CW-1:0] period, high;

   always #5 clk = ~clk;

   slow_clk_monitor #(
      .CNT_W      (CW),
      .EXP_PERIOD (EXP),
      .TOL        (TOL),
      .TIMEOUT    (TMO),
      .LOCK_CNT   (LCK)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .slow_clk_i   (slow),
      .tick_o       (tick),
      .period_o     (period),
      .period_vld_o (vld),
      .locked_o     (locked),
      .lost_o       (lost),
      .err_o        (err),
      .high_o       (high)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Model state: sampled input history indexed by edge number since reset release.
   bit  x_hist [0:4095];
   int  n = 0;
   int  last_e = 0;
   int  m_state = M_IDLE;
   int  m_good = 0;
   bit  e_tick, e_vld, e_err, e_locked, e_lost;
   int  e_period, e_high;

   // Model: a rise becomes visible two edges after the input is first sampled high after a
   // sampled low; the measured period is the edge distance between visible rises.
   always @(posedge clk) begin
      if (rst) begin
         n = 0; last_e = 0; m_state = M_IDLE; m_good = 0;
         e_tick = 0; e_vld = 0; e_err = 0; e_locked = 0; e_lost = 0;
         e_period = 0; e_high = 0;
      end else begin
         int elapsed, p, hsum;
         bit r;
         n = n + 1;
         if (n > 4095) $fatal(1, "FAIL model_overflow actual=%0d required<4096", n);
         x_hist[n] = slow;
         r = (n >= 4) && x_hist[n-2] && !x_hist[n-3];
         elapsed = n - last_e;
         e_tick = r; e_vld = 0; e_err = 0;
         if (r) begin
            p = (elapsed > TMO + 1) ? TMO + 1 : elapsed;
            hsum = 0;
            if (m_state == M_ACQ || m_state == M_LOCKED)
               for (int i = last_e - 1; i <= n - 2; i++) hsum += x_hist[i];
            case (m_state)
               M_IDLE, M_LOST: begin m_state = M_ACQ; m_good = 0; end
               M_ACQ: begin
                  e_vld = 1; e_period = p; e_high = DUTY ? hsum : 0;
                  if (p >= EXP - TOL && p <= EXP + TOL) begin
                     m_good++;
                     if (m_good >= LCK) m_state = M_LOCKED;
                  end else m_good = 0;
               end
               default: begin
                  e_vld = 1; e_period = p; e_high = DUTY ? hsum : 0;
                  if (!(p >= EXP - TOL && p <= EXP + TOL)) begin
                     e_err = 1; m_state = M_ACQ; m_good = 0;
                  end
               end
            endcase
            last_e = n;
         end else if (m_state != M_LOST && elapsed - 1 >= TMO) begin
            m_state = M_LOST;
         end
         e_locked = (m_state == M_LOCKED);
         e_lost   = (m_state == M_LOST);
      end
   end

   int tick_seen = 0, vld_seen = 0, err_seen = 0;

   // Single compare process against the model, plus event counters for literal checkpoints.
   always @(negedge clk) begin
      if (!rst && n > 0) begin
         check("tick",   tick,   e_tick);
         check("vld",    vld,    e_vld);
         check("err",    err,    e_err);
         check("locked", locked, e_locked);
         check("lost",   lost,   e_lost);
         check("period", period, e_period);
         check("high",   high,   e_high);
         tick_seen += int'(tick);
         vld_seen  += int'(vld);
         err_seen  += int'(err);
      end
   end

   task automatic drive(input bit level, input int cycles);
      slow = level;
      repeat (cycles) @(negedge clk);
   endtask

   // One slow period of p cycles starting with a rise, high for hi cycles.
   task automatic pulse(input int p, input int hi, input bit lat);
      slow = 1'b1;
      for (int i = 1; i <= hi; i++) begin
         @(negedge clk);
         if (lat && i <= 3) check("tick_latency", tick, (i == 3) ? 1 : 0);
      end
      slow = 1'b0;
      repeat (p - hi) @(negedge clk);
   endtask

   int vc;

   initial begin
      rst = 1'b1; slow = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tick", tick, 0);   check("rst_vld", vld, 0);   check("rst_locked", locked, 0);
      check("rst_lost", lost, 0);   check("rst_err", err, 0);   check("rst_period", period, 0);
      check("rst_high", high, 0);
      rst = 1'b0;

      // Slow clock high through reset release: no tick.
      drive(1, 20); #2;
      check("t1_ticks", tick_seen, 0); check("t1_vlds", vld_seen, 0);
      check("t1_locked", locked, 0);   check("t1_lost", lost, 0);

      // 8/8 square wave: lock after the 3rd rise.
      drive(0, 8);
      for (int i = 0; i < 4; i++) pulse(16, 8, i < 3);
      #2;
      check("t2_locked", locked, 1); check("t2_period", period, 16);
      check("t2_vlds", vld_seen, 3); check("t2_ticks", tick_seen, 4);

      // One 20-cycle period while locked, then relock.
      pulse(20, 8, 0); pulse(16, 8, 0); #2;
      check("t3_errs", err_seen, 1); check("t3_period", period, 20); check("t3_locked", locked, 0);
      pulse(16, 8, 0); pulse(16, 8, 0); pulse(20, 8, 0); #2;
      check("t3_relocked", locked, 1);

      // 20 (error) then 15, 17 lock; 18 errors out.
      pulse(15, 8, 0); pulse(17, 8, 0); pulse(18, 8, 0); #2;
      check("t4_errs", err_seen, 2); check("t4_locked", locked, 1); check("t4_period", period, 17);
      pulse(16, 8, 0); #2;
      check("t4_errs2", err_seen, 3); check("t4_unlocked", locked, 0); check("t4_period2", period, 18);

      // Relock, then stop the slow clock.
      pulse(16, 8, 0); pulse(16, 8, 0);
      drive(1, 8); drive(0, 50); #2;
      check("t5_lost", lost, 1); check("t5_locked", locked, 0);
      vc = vld_seen;
      pulse(16, 4, 0); #2;
      check("t5_lost_clr", lost, 0); check("t5_no_vld", vld_seen, vc);
      pulse(16, 4, 0); pulse(16, 4, 0);
      drive(1, 6); #2;
      check("t5_relocked", locked, 1); check("t6_period", period, 16);
      check("t6_high", high, DUTY ? 4 : 0);

      // Mid-operation reset.
      drive(0, 5);
      rst = 1'b1; #2;
      check("mrst_locked", locked, 0); check("mrst_period", period, 0); check("mrst_high", high, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      drive(0, 10); #2;
      check("mrst_after_locked", locked, 0); check("mrst_after_lost", lost, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
